// File: rtl/dpram_core.sv
// dpram_core: one-write/one-read RAM in a single clock domain with
// registered read data, write-first bypass on address collision, a
// per-word "written" flag and an occupancy count of distinct words written.
module dpram_core #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_enb,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_enb,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  rd_uninit,
    output logic [ADDR_WIDTH:0]   occupancy
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    // Storage is cleared in a single reset cycle, so it lives in flops
    // rather than a block RAM.
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0]      r_written;

    logic [DATA_WIDTH-1:0] r_rd_data;
    logic                  r_rd_valid;
    logic                  r_rd_uninit;
    logic [ADDR_WIDTH:0]   r_occupancy;

    logic                  w_collide;
    logic                  w_new_word;

    assign w_collide  = wr_enb && (wr_addr == rd_addr);
    assign w_new_word = wr_enb && !r_written[wr_addr];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_word
            // Per-word storage and written flag, loaded when this word is addressed.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_mem[gi]     <= '0;
                    r_written[gi] <= 1'b0;
                end else if (wr_enb && (wr_addr == ADDR_WIDTH'(gi))) begin
                    r_mem[gi]     <= wr_data;
                    r_written[gi] <= 1'b1;
                end
            end
        end
    endgenerate

    // Occupancy only counts first writes, so it stops at DEPTH without wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_occupancy <= '0;
        end else if (w_new_word) begin
            r_occupancy <= r_occupancy + (ADDR_WIDTH + 1)'(1);
        end
    end

    // Registered read port; a same-address write wins over stored contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data   <= '0;
            r_rd_valid  <= 1'b0;
            r_rd_uninit <= 1'b0;
        end else if (rd_enb) begin
            r_rd_valid <= 1'b1;
            if (w_collide) begin
                r_rd_data   <= wr_data;
                r_rd_uninit <= 1'b0;
            end else begin
                r_rd_data   <= r_mem[rd_addr];
                r_rd_uninit <= ~r_written[rd_addr];
            end
        end else begin
            r_rd_valid  <= 1'b0;
            r_rd_uninit <= 1'b0;
        end
    end

    assign rd_data   = r_rd_data;
    assign rd_valid  = r_rd_valid;
    assign rd_uninit = r_rd_uninit;
    assign occupancy = r_occupancy;

endmodule

// File: tb/tb_dpram_core.sv
// tb_dpram_core: directed vector table plus hand-written fill / back-to-back
// read / mid-operation reset sequences for dpram_core.
module tb_dpram_core;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int DEPTH = 2 ** AW;

    logic          clk;
    logic          rst;
    logic          wr_enb;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          rd_enb;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          rd_uninit;
    logic [AW:0]   occupancy;

    int n_tests;
    int n_fail;

    dpram_core #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_enb    (wr_enb),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_enb    (rd_enb),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .rd_uninit (rd_uninit),
        .occupancy (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          rst;
        logic          we;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic          re;
        logic [AW-1:0] ra;
        logic [DW-1:0] e_data;
        logic          e_valid;
        logic          e_uninit;
        logic [AW:0]   e_occ;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
        end
    endtask

    // Drive one cycle of inputs on the falling edge, return 1ns after the rising edge.
    task automatic step(input logic r, input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                        input logic re, input logic [AW-1:0] ra);
        @(negedge clk);
        rst = r; wr_enb = we; wr_addr = wa; wr_data = wd; rd_enb = re; rd_addr = ra;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input int idx, input logic [DW-1:0] ed, input logic ev,
                             input logic eu, input logic [AW:0] eo);
        check({tag, ".rd_data"},   idx, 32'(rd_data),   32'(ed));
        check({tag, ".rd_valid"},  idx, 32'(rd_valid),  32'(ev));
        check({tag, ".rd_uninit"}, idx, 32'(rd_uninit), 32'(eu));
        check({tag, ".occupancy"}, idx, 32'(occupancy), 32'(eo));
        $display("[TB] %s[%0d] data=%02h valid=%0b uninit=%0b occ=%0d", tag, idx, rd_data, rd_valid, rd_uninit, occupancy);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1; wr_enb = 1'b0; wr_addr = '0; wr_data = '0; rd_enb = 1'b0; rd_addr = '0;

        //          rst  we   wa     wd     re   ra     data   v    u    occ
        vecs[0]  = '{1'b1, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 5'd0};
        vecs[1]  = '{1'b1, 1'b1, 4'd9, 8'hEE, 1'b1, 4'd9, 8'h00, 1'b0, 1'b0, 5'd0}; // ignored under reset
        vecs[2]  = '{1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 4'd5, 8'h00, 1'b1, 1'b1, 5'd0}; // read unwritten
        vecs[3]  = '{1'b0, 1'b1, 4'd3, 8'hA5, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 5'd1};
        vecs[4]  = '{1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 4'd3, 8'hA5, 1'b1, 1'b0, 5'd1};
        vecs[5]  = '{1'b0, 1'b1, 4'd7, 8'h3C, 1'b1, 4'd7, 8'h3C, 1'b1, 1'b0, 5'd2}; // bypass
        vecs[6]  = '{1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 8'h3C, 1'b0, 1'b0, 5'd2}; // data holds
        vecs[7]  = '{1'b0, 1'b1, 4'd0, 8'h11, 1'b1, 4'd1, 8'h00, 1'b1, 1'b1, 5'd3}; // concurrent
        vecs[8]  = '{1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 4'd0, 8'h11, 1'b1, 1'b0, 5'd3};
        vecs[9]  = '{1'b0, 1'b1, 4'd0, 8'h22, 1'b1, 4'd0, 8'h22, 1'b1, 1'b0, 5'd3}; // rewrite + bypass
        vecs[10] = '{1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 4'd7, 8'h3C, 1'b1, 1'b0, 5'd3};

        for (int i = 0; i < 11; i++) begin
            step(vecs[i].rst, vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].re, vecs[i].ra);
            check_all("vec", i, vecs[i].e_data, vecs[i].e_valid, vecs[i].e_uninit, vecs[i].e_occ);
        end

        // Fill from a clean reset: data = addr ^ 0xFF, occupancy climbs 1..16.
        step(1'b1, 1'b0, '0, '0, 1'b0, '0);
        check_all("fill_rst", 0, 8'h00, 1'b0, 1'b0, 5'd0);
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 1'b1, AW'(i), DW'(i) ^ 8'hFF, 1'b0, '0);
            check("fill.occupancy", i, 32'(occupancy), 32'(i + 1));
            $display("[TB] fill[%0d] occ=%0d", i, occupancy);
        end
        step(1'b0, 1'b1, 4'd0, 8'h55, 1'b0, '0);
        check_all("rewrite", 0, 8'h00, 1'b0, 1'b0, 5'd16);

        // Back-to-back reads: one word per cycle, valid held high.
        for (int i = 0; i < DEPTH; i++) begin
            logic [DW-1:0] exp_d;
            exp_d = (i == 0) ? 8'h55 : (DW'(i) ^ 8'hFF);
            step(1'b0, 1'b0, '0, '0, 1'b1, AW'(i));
            check_all("b2b", i, exp_d, 1'b1, 1'b0, 5'd16);
        end

        // Reset coincident with a read of addr 2: no valid, everything cleared.
        step(1'b1, 1'b0, '0, '0, 1'b1, 4'd2);
        check_all("midrst", 0, 8'h00, 1'b0, 1'b0, 5'd0);
        step(1'b0, 1'b0, '0, '0, 1'b1, 4'd2);
        check_all("midrst", 1, 8'h00, 1'b1, 1'b1, 5'd0);
        step(1'b0, 1'b0, '0, '0, 1'b0, '0);
        check_all("midrst", 2, 8'h00, 1'b0, 1'b0, 5'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
